// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, shift-and-add-3, one bit
// per clock, with start/done handshake, overflow and leading-zero blanking.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    request conversion of bin (ignored while busy)
//   bin      WIDTH-bit binary value, sampled on the accepting edge
//   busy     high while converting (state SHIFT)
//   done     one-cycle pulse when bcd/overflow/blank update
//   bcd      DIGITS packed BCD digits, digit 0 in bits [3:0]
//   overflow high when bin >= 10^DIGITS
//   blank    bit k high when digit k is a leading zero; bit 0 always 0
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  bsr;
    logic [BW-1:0]     work;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     work_nx;
    logic              sticky;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              last;
    logic              seen;
    logic [DIGITS-1:0] blank_nx;

    // Add-3 correction, shift step and final-digit blanking flags.
    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
            else
                adj[4*k +: 4] = work[4*k +: 4];
        end
        // Bit leaving the top digit is worth 10^DIGITS: it only marks overflow.
        carry   = adj[BW-1];
        work_nx = {adj[BW-2:0], bsr[WIDTH-1]};
        last    = (cnt == CW'(1));
        seen     = 1'b0;
        blank_nx = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            seen        = seen | (|work_nx[4*k +: 4]);
            blank_nx[k] = ~seen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bsr      <= '0;
            work     <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            blank    <= BLANK_RST;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    bsr    <= bin;
                    work   <= '0;
                    sticky <= 1'b0;
                    cnt    <= CW'(WIDTH);
                end
            end else begin
                bsr    <= bsr << 1;
                work   <= work_nx;
                sticky <= sticky | carry;
                cnt    <= cnt - CW'(1);
                if (last) begin
                    bcd      <= work_nx;
                    overflow <= sticky | carry;
                    blank    <= blank_nx;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq with three
// parameter sets (8/3, 8/2, 16/5) sharing one clock and reset.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin_t;
    int          sel;
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    logic        start_a, busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic [2:0]  blank_a;
    logic        start_b, busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  blank_b;
    logic        start_c, busy_c, done_c, ovf_c;
    logic [19:0] bcd_c;
    logic [4:0]  blank_c;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_t[7:0]),
        .busy(busy_a), .done(done_a), .bcd(bcd_a),
        .overflow(ovf_a), .blank(blank_a)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_t[7:0]),
        .busy(busy_b), .done(done_b), .bcd(bcd_b),
        .overflow(ovf_b), .blank(blank_b)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_t),
        .busy(busy_c), .done(done_c), .bcd(bcd_c),
        .overflow(ovf_c), .blank(blank_c)
    );

    logic        o_busy, o_done, o_ovf;
    logic [19:0] o_bcd;
    logic [4:0]  o_blank;

    always_comb begin
        o_busy  = busy_a;
        o_done  = done_a;
        o_ovf   = ovf_a;
        o_bcd   = 20'(bcd_a);
        o_blank = 5'(blank_a);
        if (sel == 1) begin
            o_busy  = busy_b;
            o_done  = done_b;
            o_ovf   = ovf_b;
            o_bcd   = 20'(bcd_b);
            o_blank = 5'(blank_b);
        end else if (sel == 2) begin
            o_busy  = busy_c;
            o_done  = done_c;
            o_ovf   = ovf_c;
            o_bcd   = bcd_c;
            o_blank = blank_c;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Wait for done at negedges; n counts edges since (and including) E0.
    task automatic wait_done(inout int n, inout int nb);
        while (!o_done && n < 100) begin
            @(negedge clk);
            n++;
            if (o_busy) nb++;
        end
    endtask

    task automatic conv(input int s, input logic [15:0] v,
                        input logic [19:0] eb, input logic eo,
                        input logic [4:0] ebl, input int elat,
                        input string tag);
        int n;
        int nb;
        sel = s;
        @(negedge clk);
        start = 1'b1;
        bin_t = v;
        @(negedge clk);
        start = 1'b0;
        bin_t = '0;
        n  = 1;
        nb = o_busy ? 1 : 0;
        wait_done(n, nb);
        chk({tag, " latency"}, n, elat);
        chk({tag, " busy cycles"}, nb, elat - 1);
        chk({tag, " bcd"}, o_bcd, eb);
        chk({tag, " overflow"}, o_ovf, eo);
        chk({tag, " blank"}, o_blank, ebl);
        @(negedge clk);
        chk({tag, " done width"}, o_done, 1'b0);
    endtask

    initial begin
        int n;
        int nb;
        int dn;
        rst   = 1'b1;
        start = 1'b0;
        bin_t = '0;
        sel   = 0;
        #12;
        chk("rst busy", busy_a, 1'b0);
        chk("rst done", done_a, 1'b0);
        chk("rst bcd", bcd_a, 12'h000);
        chk("rst overflow", ovf_a, 1'b0);
        chk("rst blank a", blank_a, 3'b110);
        chk("rst blank b", blank_b, 2'b10);
        chk("rst blank c", blank_c, 5'b11110);
        @(negedge clk);
        rst = 1'b0;

        conv(0, 16'd255, 20'h255, 1'b0, 5'b000, 9, "a255");
        conv(0, 16'd0, 20'h000, 1'b0, 5'b110, 9, "a0");
        conv(0, 16'd7, 20'h007, 1'b0, 5'b110, 9, "a7");
        conv(0, 16'd42, 20'h042, 1'b0, 5'b100, 9, "a42");

        conv(1, 16'd255, 20'h55, 1'b1, 5'b00, 9, "b255");
        conv(1, 16'd99, 20'h99, 1'b0, 5'b00, 9, "b99");
        conv(1, 16'd100, 20'h00, 1'b1, 5'b10, 9, "b100");

        conv(2, 16'd65535, 20'h65535, 1'b0, 5'b00000, 17, "c65535");
        conv(2, 16'd10000, 20'h10000, 1'b0, 5'b00000, 17, "c10000");
        conv(2, 16'd5, 20'h00005, 1'b0, 5'b11110, 17, "c5");

        // start while busy is ignored
        sel = 0;
        @(negedge clk);
        start = 1'b1;
        bin_t = 16'd123;
        @(negedge clk);
        start = 1'b0;
        n  = 1;
        nb = 0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin_t = 16'd200;
        @(negedge clk);
        start = 1'b0;
        bin_t = '0;
        n = 5;
        wait_done(n, nb);
        chk("ign latency", n, 9);
        chk("ign bcd", o_bcd, 20'h123);
        chk("ign blank", o_blank, 5'b000);

        // start held through done: back-to-back with no gap
        @(negedge clk);
        start = 1'b1;
        bin_t = 16'd42;
        @(negedge clk);
        n = 1;
        wait_done(n, nb);
        chk("b2b first latency", n, 9);
        chk("b2b first bcd", o_bcd, 20'h042);
        bin_t = 16'd7;
        @(negedge clk);
        chk("b2b no gap busy", o_busy, 1'b1);
        chk("b2b done low", o_done, 1'b0);
        start = 1'b0;
        n = 1;
        wait_done(n, nb);
        chk("b2b second latency", n, 9);
        chk("b2b second bcd", o_bcd, 20'h007);
        chk("b2b second blank", o_blank, 5'b110);

        // asynchronous reset mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin_t = 16'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid rst busy", busy_a, 1'b0);
        chk("mid rst done", done_a, 1'b0);
        chk("mid rst bcd", bcd_a, 12'h000);
        chk("mid rst overflow", ovf_a, 1'b0);
        chk("mid rst blank", blank_a, 3'b110);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_a) dn++;
        end
        chk("mid rst no done", dn, 0);
        conv(0, 16'd200, 20'h200, 1'b0, 5'b000, 9, "a200");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
